// File: rtl/jt1943_objsched.sv
// jt1943_objsched: per-line sprite scheduler between object RAM and drawer.
// Define JT1943_OBJ_OVF_EN to scan past 23 hits and report sprite overflow.
module jt1943_objsched (
    input  logic       rst,
    input  logic       clk,
    input  logic       cen6,
    input  logic       HINIT,
    input  logic [7:0] VF,
    output logic [8:0] obj_ram_addr,
    input  logic [7:0] obj_ram_data,
    output logic [3:0] pxlcnt,
    output logic [4:0] objcnt,
    output logic [7:0] objbuf_data,
    output logic       obj_ovf
);

    typedef enum logic [2:0] {
        IDLE, YCHK, CP0, CP1, CP2, CP3, NEXT
    } st_t;

    st_t        st;
    logic [6:0] n;
    logic       wb;
    logic [4:0] cnt [2];
    logic [4:0] s;
    logic [7:0] lbuf [256];

    logic [4:0] cnt_w, cnt_rd;
    logic [7:0] vn, objy, objy_end;
    logic       hit;
    logic       buf_we;
    logic [1:0] buf_byte;
    logic [7:0] buf_wa;
    logic [3:0] pxl_nx;
    logic [4:0] s_nx;
    logic       rb_nx;

`ifdef JT1943_OBJ_OVF_EN
    logic       ovf_scan;
`else
    assign obj_ovf = 1'b0;
`endif

    assign cnt_w    = cnt[wb];
    assign cnt_rd   = cnt[~wb];
    assign vn       = VF + 8'd1;
    assign objy     = obj_ram_data - 8'd2;
    assign objy_end = objy + 8'd16;
    assign hit      = (vn >= objy) && (vn < objy_end);
    assign buf_wa   = {wb, cnt_w + 5'd1, buf_byte};
    assign objcnt   = (s != 5'd0 && s <= cnt_rd) ? s : 5'd0;

    // Byte k of an entry arrives one cen6 after its address, i.e. in state CPk
    always_comb begin
        buf_we   = 1'b0;
        buf_byte = 2'd0;
        unique case (st)
            CP0: begin buf_we = 1'b1; buf_byte = 2'd0; end
            CP1: begin buf_we = 1'b1; buf_byte = 2'd1; end
            CP2: begin buf_we = 1'b1; buf_byte = 2'd2; end
            CP3: begin buf_we = 1'b1; buf_byte = 2'd3; end
            default: ;
        endcase
        if (rst || !cen6 || HINIT) buf_we = 1'b0;
    end

    always_comb begin
        pxl_nx = pxlcnt + 4'd1;
        s_nx   = s;
        rb_nx  = ~wb;
        if (pxlcnt == 4'd15 && s != 5'd24) s_nx = s + 5'd1;
        if (HINIT) begin
            pxl_nx = 4'd0;
            s_nx   = 5'd0;
            rb_nx  = wb;
        end
    end

    // NEXT doubles as the y-address fetch so a miss costs two cen6
    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= IDLE;
            n            <= 7'd0;
            wb           <= 1'b0;
            cnt[0]       <= 5'd0;
            cnt[1]       <= 5'd0;
            obj_ram_addr <= 9'd0;
`ifdef JT1943_OBJ_OVF_EN
            ovf_scan     <= 1'b0;
            obj_ovf      <= 1'b0;
`endif
        end else if (cen6) begin
            if (HINIT) begin
                wb           <= ~wb;
                cnt[~wb]     <= 5'd0;
                n            <= 7'd0;
                obj_ram_addr <= {7'd0, 2'd2};
                st           <= YCHK;
`ifdef JT1943_OBJ_OVF_EN
                obj_ovf      <= ovf_scan;
                ovf_scan     <= 1'b0;
`endif
            end else begin
                unique case (st)
                    IDLE: ;
                    YCHK: begin
                        if (!hit) begin
                            st <= NEXT;
                        end else if (cnt_w != 5'd23) begin
                            obj_ram_addr <= {n, 2'd0};
                            st           <= CP0;
                        end else begin
`ifdef JT1943_OBJ_OVF_EN
                            ovf_scan <= 1'b1;
`endif
                            st <= NEXT;
                        end
                    end
                    CP0: begin
                        obj_ram_addr <= {n, 2'd1};
                        st           <= CP1;
                    end
                    CP1: begin
                        obj_ram_addr <= {n, 2'd2};
                        st           <= CP2;
                    end
                    CP2: begin
                        obj_ram_addr <= {n, 2'd3};
                        st           <= CP3;
                    end
                    CP3: begin
                        cnt[wb] <= cnt_w + 5'd1;
`ifdef JT1943_OBJ_OVF_EN
                        st <= NEXT;
`else
                        st <= (cnt_w == 5'd22) ? IDLE : NEXT;
`endif
                    end
                    NEXT: begin
                        if (n == 7'd127) begin
                            st <= IDLE;
                        end else begin
                            n            <= n + 7'd1;
                            obj_ram_addr <= {n + 7'd1, 2'd2};
                            st           <= YCHK;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) lbuf[buf_wa] <= obj_ram_data;
    end

    // Buffer is read with next-cycle indices so each byte lines up with its pxlcnt
    always_ff @(posedge clk) begin
        if (rst) begin
            pxlcnt      <= 4'd0;
            s           <= 5'd0;
            objbuf_data <= 8'd0;
        end else if (cen6) begin
            pxlcnt      <= pxl_nx;
            s           <= s_nx;
            objbuf_data <= lbuf[{rb_nx, s_nx, pxl_nx[1:0]}];
        end
    end

endmodule

// File: tb/tb_jt1943_objsched.sv
// tb_jt1943_objsched: directed self-checking bench for jt1943_objsched.
// Honours JT1943_OBJ_OVF_EN when choosing overflow expectations.
module tb_jt1943_objsched;

    logic       rst, clk, cen6, HINIT;
    logic [7:0] VF, obj_ram_data, objbuf_data;
    logic [8:0] obj_ram_addr;
    logic [3:0] pxlcnt;
    logic [4:0] objcnt;
    logic       obj_ovf;
    logic [7:0] ram [512];
    logic [1:0] div = 2'd0;
    int         checks = 0;
    int         errors = 0;

    jt1943_objsched dut (
        .rst          (rst),
        .clk          (clk),
        .cen6         (cen6),
        .HINIT        (HINIT),
        .VF           (VF),
        .obj_ram_addr (obj_ram_addr),
        .obj_ram_data (obj_ram_data),
        .pxlcnt       (pxlcnt),
        .objcnt       (objcnt),
        .objbuf_data  (objbuf_data),
        .obj_ovf      (obj_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) div <= div + 2'd1;
    assign cen6 = (div == 2'd3);
    always @(posedge clk) obj_ram_data <= ram[obj_ram_addr];

    task automatic cyc();
        @(posedge clk);
        while (!cen6) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        for (int i = 0; i < k; i++) cyc();
    endtask

    task automatic new_line(input logic [7:0] vf);
        VF    = vf;
        HINIT = 1'b1;
        cyc();
        HINIT = 1'b0;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    endtask

    task automatic fill_all_hit();
        for (int i = 0; i < 128; i++) begin
            ram[i*4]   = 8'(i);
            ram[i*4+1] = 8'(i) ^ 8'hA5;
            ram[i*4+2] = 8'h52;
            ram[i*4+3] = 8'(i) + 8'h40;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        HINIT = 1'b0;
        VF    = 8'h00;
        fill_zero();
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (obj_ram_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_addr: got %h expected 000", obj_ram_addr);
        end
        checks++;
        if (pxlcnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_pxlcnt: got %h expected 0", pxlcnt);
        end
        checks++;
        if (objcnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_objcnt: got %h expected 0", objcnt);
        end
        checks++;
        if (objbuf_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_objbuf: got %h expected 00", objbuf_data);
        end
        checks++;
        if (obj_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b expected 0", obj_ovf);
        end
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] eb [4];
        eb[0] = 8'h34;
        eb[1] = 8'h27;
        eb[2] = 8'h52;
        eb[3] = 8'h80;
        fill_zero();
        for (int b = 0; b < 4; b++) ram[20+b] = eb[b];
        new_line(8'h55);
        wait_cyc(383);
        new_line(8'h55);
        checks++;
        if (objcnt !== 5'd0) begin
            errors++;
            $display("FAIL single_s0: got %0d expected 0", objcnt);
        end
        wait_cyc(16);
        checks++;
        if (objcnt !== 5'd1) begin
            errors++;
            $display("FAIL single_s1: got %0d expected 1", objcnt);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (pxlcnt !== 4'(b) || objbuf_data !== eb[b]) begin
                errors++;
                $display("FAIL single_b%0d: got pxl %0d data %h expected pxl %0d data %h",
                         b, pxlcnt, objbuf_data, b, eb[b]);
            end
            if (b < 3) cyc();
        end
        wait_cyc(13);
        checks++;
        if (objcnt !== 5'd0) begin
            errors++;
            $display("FAIL single_s2: got %0d expected 0", objcnt);
        end
    endtask

    task automatic zone_run(input string nm, input logic [7:0] y,
                            input logic [7:0] vf, input logic exp_hit);
        logic [4:0] ec;
        fill_zero();
        ram[0] = 8'h77;
        ram[2] = y;
        ec = exp_hit ? 5'd1 : 5'd0;
        new_line(vf);
        wait_cyc(383);
        new_line(vf);
        wait_cyc(16);
        checks++;
        if (objcnt !== ec) begin
            errors++;
            $display("FAIL %s vf=%h: objcnt got %0d expected %0d", nm, vf, objcnt, ec);
        end
        if (exp_hit) begin
            checks++;
            if (objbuf_data !== 8'h77) begin
                errors++;
                $display("FAIL %s vf=%h: data got %h expected 77", nm, vf, objbuf_data);
            end
        end
    endtask

    task automatic test_zone();
        zone_run("zone", 8'h12, 8'h0E, 1'b0);
        zone_run("zone", 8'h12, 8'h0F, 1'b1);
        zone_run("zone", 8'h12, 8'h1E, 1'b1);
        zone_run("zone", 8'h12, 8'h1F, 1'b0);
    endtask

    task automatic test_wrap();
        zone_run("wrap", 8'h01, 8'hFE, 1'b0);
        zone_run("wrap", 8'h01, 8'hFF, 1'b0);
        zone_run("wrap", 8'h01, 8'h04, 1'b0);
        zone_run("wrap", 8'h01, 8'h0D, 1'b0);
    endtask

    task automatic test_overflow();
        logic [8:0] exp_end;
        logic       exp_ovf;
        logic [7:0] e;
`ifdef JT1943_OBJ_OVF_EN
        exp_end = 9'd510;
        exp_ovf = 1'b1;
`else
        exp_end = 9'd91;
        exp_ovf = 1'b0;
`endif
        fill_all_hit();
        new_line(8'h55);
        wait_cyc(139);
`ifndef JT1943_OBJ_OVF_EN
        checks++;
        if (obj_ram_addr !== 9'd91) begin
            errors++;
            $display("FAIL ovf_stop139: got %0d expected 91", obj_ram_addr);
        end
`endif
        wait_cyc(221);
        checks++;
        if (obj_ram_addr !== exp_end) begin
            errors++;
            $display("FAIL ovf_end360: got %0d expected %0d", obj_ram_addr, exp_end);
        end
        wait_cyc(20);
        checks++;
        if (obj_ram_addr !== exp_end) begin
            errors++;
            $display("FAIL ovf_end380: got %0d expected %0d", obj_ram_addr, exp_end);
        end
        new_line(8'h55);
        checks++;
        if (obj_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_flag: got %b expected %b", obj_ovf, exp_ovf);
        end
        wait_cyc(16);
        for (int k = 1; k <= 23; k++) begin
            e = 8'(k - 1);
            checks++;
            if (objcnt !== 5'(k)) begin
                errors++;
                $display("FAIL ovf_objcnt: got %0d expected %0d", objcnt, k);
            end
            checks++;
            if (objbuf_data !== e) begin
                errors++;
                $display("FAIL ovf_b0 slot%0d: got %h expected %h", k, objbuf_data, e);
            end
            cyc();
            checks++;
            if (objbuf_data !== (e ^ 8'hA5)) begin
                errors++;
                $display("FAIL ovf_b1 slot%0d: got %h expected %h", k, objbuf_data, e ^ 8'hA5);
            end
            cyc();
            checks++;
            if (objbuf_data !== 8'h52) begin
                errors++;
                $display("FAIL ovf_b2 slot%0d: got %h expected 52", k, objbuf_data);
            end
            cyc();
            checks++;
            if (objbuf_data !== e + 8'h40) begin
                errors++;
                $display("FAIL ovf_b3 slot%0d: got %h expected %h", k, objbuf_data, e + 8'h40);
            end
            wait_cyc(13);
        end
        checks++;
        if (objcnt !== 5'd0) begin
            errors++;
            $display("FAIL ovf_s24: got %0d expected 0", objcnt);
        end
    endtask

    task automatic test_abort_reset();
        fill_all_hit();
        new_line(8'h55);
        wait_cyc(39);
        new_line(8'h55);
        wait_cyc(16);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (objcnt !== 5'(k)) begin
                errors++;
                $display("FAIL abort_objcnt: got %0d expected %0d", objcnt, k);
            end
            if (k == 6) begin
                checks++;
                if (objbuf_data !== 8'h05) begin
                    errors++;
                    $display("FAIL abort_b0 slot6: got %h expected 05", objbuf_data);
                end
            end
            wait_cyc(16);
        end
        checks++;
        if (objcnt !== 5'd0) begin
            errors++;
            $display("FAIL abort_s7: got %0d expected 0", objcnt);
        end
        new_line(8'h55);
        wait_cyc(16 * 3 + 5);
        checks++;
        if (objcnt !== 5'd3 || pxlcnt !== 4'd5) begin
            errors++;
            $display("FAIL middraw_pre: got objcnt %0d pxl %0d expected 3 5", objcnt, pxlcnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (objcnt !== 5'd0 || pxlcnt !== 4'd0) begin
            errors++;
            $display("FAIL middraw_rst: got objcnt %0d pxl %0d expected 0 0", objcnt, pxlcnt);
        end
        checks++;
        if (obj_ram_addr !== 9'd0 || objbuf_data !== 8'd0 || obj_ovf !== 1'b0) begin
            errors++;
            $display("FAIL middraw_rst_out: got addr %0d data %h ovf %b expected 0 00 0",
                     obj_ram_addr, objbuf_data, obj_ovf);
        end
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        rst   = 1'b1;
        HINIT = 1'b0;
        VF    = 8'h00;
        test_reset();
        test_single();
        test_zone();
        test_wrap();
        test_overflow();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
